// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK-based up/down counter: per-bit JK excitation codes
// and the operation selected for the current cycle.
package jk_updown_counter_pkg;

  typedef logic [1:0] jk_code_t;

  localparam jk_code_t JK_HOLD = 2'b00;
  localparam jk_code_t JK_RST  = 2'b01;
  localparam jk_code_t JK_SET  = 2'b10;
  localparam jk_code_t JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to q=0.
// qbar is derived from the same register so it is always the exact complement.
module jk_cell
  import jk_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_RST:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TGL:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MOD up/down counter: excitation logic drives a bank of JK cells,
// plus terminal-count decode, a registered wrap pulse and a sticky load-range error.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);

  op_e                        w_op;
  logic                       w_at_max;
  logic                       w_at_zero;
  logic                       w_load_oor;
  logic [WIDTH-1:0]           w_load_val;
  logic                       w_wrap_evt;
  logic [WIDTH-1:0][1:0]      w_jk;
  logic                       r_wrap;
  logic                       r_err;

  assign w_at_max   = (q == LP_MAX);
  assign w_at_zero  = (q == '0);
  // When MOD == 2**WIDTH, LP_MAX is all ones and no load value can exceed it.
  assign w_load_oor = (d > LP_MAX);
  assign w_load_val = w_load_oor ? LP_MAX : d;

  always_comb begin
    w_op = OP_HOLD;
    if (load)    w_op = OP_LOAD;
    else if (en) w_op = up ? OP_UP : OP_DOWN;
  end

  always_comb begin
    logic v_ones;
    logic v_zeros;
    v_ones  = 1'b1;
    v_zeros = 1'b1;
    w_jk    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_jk[i] = JK_HOLD;
      case (w_op)
        OP_LOAD: w_jk[i] = w_load_val[i] ? JK_SET : JK_RST;
        OP_UP: begin
          if (w_at_max) w_jk[i] = q[i] ? JK_RST : JK_HOLD;
          else          w_jk[i] = v_ones ? JK_TGL : JK_HOLD;
        end
        OP_DOWN: begin
          if (w_at_zero) w_jk[i] = LP_MAX[i] ? JK_SET : JK_RST;
          else           w_jk[i] = v_zeros ? JK_TGL : JK_HOLD;
        end
        default: w_jk[i] = JK_HOLD;
      endcase
      // running prefix AND of lower bits for the next stage
      v_ones  = v_ones & q[i];
      v_zeros = v_zeros & ~q[i];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (w_jk[g][1]),
      .k    (w_jk[g][0]),
      .q    (q[g]),
      .qbar (qbar[g])
    );
  end

  assign w_wrap_evt = ((w_op == OP_UP) && w_at_max) || ((w_op == OP_DOWN) && w_at_zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_evt;
      if (load && w_load_oor) r_err <= 1'b1;
      else if (err_clr)       r_err <= 1'b0;
    end
  end

  assign tc   = en & (up ? w_at_max : w_at_zero);
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter (WIDTH=4, MOD=10): directed scenarios
// followed by random traffic, all compared against a plain-arithmetic reference model.
module tb_jk_updown_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  int m_q    = 0;
  int m_wrap = 0;
  int m_err  = 0;

  jk_updown_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .up     (up),
    .load   (load),
    .d      (d),
    .err_clr(err_clr),
    .q      (q),
    .qbar   (qbar),
    .tc     (tc),
    .wrap   (wrap),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_tc();
    if (!en) return 0;
    return up ? int'(m_q == MOD - 1) : int'(m_q == 0);
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, "_q"},    int'(q),    m_q);
    check_val({tag, "_qbar"}, int'(qbar), (~m_q) & ((1 << WIDTH) - 1));
    check_val({tag, "_tc"},   int'(tc),   exp_tc());
    check_val({tag, "_wrap"}, int'(wrap), m_wrap);
    check_val({tag, "_err"},  int'(err),  m_err);
  endtask

  // One clock: advance the model on the edge using the inputs held over it, then check.
  task automatic cycle(input string tag);
    int dv;
    @(posedge clk);
    dv = int'(d);
    if (load) begin
      m_q    = (dv >= MOD) ? MOD - 1 : dv;
      m_wrap = 0;
    end else if (en && up) begin
      m_wrap = int'(m_q == MOD - 1);
      m_q    = (m_q + 1) % MOD;
    end else if (en) begin
      m_wrap = int'(m_q == 0);
      m_q    = (m_q + MOD - 1) % MOD;
    end else begin
      m_wrap = 0;
    end
    if (load && dv >= MOD) m_err = 1;
    else if (err_clr)      m_err = 0;
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic i_en, input logic i_up, input logic i_load,
                       input int i_d, input logic i_clr);
    en      = i_en;
    up      = i_up;
    load    = i_load;
    d       = WIDTH'(i_d);
    err_clr = i_clr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(0, 1, 0, 0, 0);
    #3;
    check_all("rst");
    #4 reset = 1'b0;

    // up count 0 -> 1..9,0,1,2
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle("up");

    // down count from 1 -> 0,9,8
    drive(0, 1, 1, 1, 0);
    cycle("ld1");
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("down");

    // load wins over count
    drive(1, 1, 1, 5, 0);
    cycle("ldprio");
    check_val("ldprio_const", int'(q), 5);

    // out-of-range load, sticky err, clear, set-wins
    drive(0, 1, 1, 12, 0);
    cycle("bad");
    check_val("bad_const_q", int'(q), 9);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("sticky");
    drive(0, 1, 0, 0, 1);
    cycle("clr");
    check_val("clr_const_err", int'(err), 0);
    drive(0, 1, 1, 13, 1);
    cycle("clrset");
    check_val("clrset_const_err", int'(err), 1);

    // hold at 4
    drive(0, 1, 1, 4, 1);
    cycle("ld4");
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle("hold");

    // reset asserted between edges at q=7
    drive(1, 1, 1, 6, 0);
    cycle("ld6");
    drive(1, 1, 0, 0, 0);
    cycle("to7");
    #2 reset = 1'b1;
    #1;
    m_q = 0; m_wrap = 0; m_err = 0;
    check_all("midrst");
    #1 reset = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0));
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
